// File: rtl/mdu_iterative_if.sv
// ============================================================================
// Module : mdu_iterative_if
// Brief  : Request/response bundle between core control and the iterative MDU.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mdu_iterative_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [2:0]       Funct3;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [4:0]       RdIn;
    logic             Flush;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Result;
    logic [4:0]       RdOut;

    modport master (
        output Start, Funct3, SrcA, SrcB, RdIn, Flush,
        input  Busy, Done, Result, RdOut
    );

    modport slave (
        input  Start, Funct3, SrcA, SrcB, RdIn, Flush,
        output Busy, Done, Result, RdOut
    );
endinterface

`default_nettype wire

// File: rtl/mdu_iterative.sv
// ============================================================================
// Module : mdu_iterative
// Brief  : Iterative RV32M multiply/divide, one bit per cycle on magnitudes.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_iterative #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    mdu_iterative_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CW-1:0]      count;
    logic [2:0]         op;
    logic [4:0]         rd;
    logic [WIDTH-1:0]   operand;
    logic [2*WIDTH-1:0] acc;
    logic               neg_res;
    logic               neg_a;
    logic [WIDTH-1:0]   result;
    logic [4:0]         rd_out;

    logic               load;
    logic               fast_load;
    logic               step;
    logic               finish;

    // Request decode and fast-path detection
    logic               a_signed;
    logic               b_signed;
    logic               a_neg_in;
    logic               b_neg_in;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               div_by_zero;
    logic               overflow;
    logic               fast;
    logic [WIDTH-1:0]   fast_result;

    assign a_signed    = (bus.Funct3 == 3'b001) || (bus.Funct3 == 3'b010) ||
                         (bus.Funct3 == 3'b100) || (bus.Funct3 == 3'b110);
    assign b_signed    = (bus.Funct3 == 3'b001) || (bus.Funct3 == 3'b100) ||
                         (bus.Funct3 == 3'b110);
    assign a_neg_in    = a_signed && bus.SrcA[WIDTH-1];
    assign b_neg_in    = b_signed && bus.SrcB[WIDTH-1];
    assign a_mag       = a_neg_in ? -bus.SrcA : bus.SrcA;
    assign b_mag       = b_neg_in ? -bus.SrcB : bus.SrcB;
    assign div_by_zero = bus.Funct3[2] && (bus.SrcB == '0);
    assign overflow    = bus.Funct3[2] && !bus.Funct3[0] &&
                         (bus.SrcA == {1'b1, {(WIDTH-1){1'b0}}}) && (&bus.SrcB);
    assign fast        = div_by_zero || overflow;
    assign fast_result = div_by_zero ? (bus.Funct3[1] ? bus.SrcA : '1)
                                     : (bus.Funct3[1] ? '0 : bus.SrcA);

    // acc holds {high, low}: product accumulator or {remainder, quotient}
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH:0]     div_rem;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] acc_next;

    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    assign mul_next  = {mul_sum, acc[WIDTH-1:1]};
    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, operand};
    assign div_rem   = div_ge ? (div_shift - {1'b0, operand}) : div_shift;
    assign div_next  = {div_rem[WIDTH-1:0], acc[WIDTH-2:0], div_ge};
    assign acc_next  = op[2] ? div_next : mul_next;

    // Sign fix-up applied to the value produced by the final iteration
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   quot_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   final_result;

    assign prod_signed  = neg_res ? -acc_next : acc_next;
    assign quot_s       = neg_res ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
    assign rem_s        = neg_a ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
    assign final_result = op[2] ? (op[1] ? rem_s : quot_s)
                                : ((op[1:0] == 2'b00) ? prod_signed[WIDTH-1:0]
                                                      : prod_signed[2*WIDTH-1:WIDTH]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        fast_load  = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Start && !bus.Flush) begin
                    if (fast) begin
                        state_next = DONE;
                        fast_load  = 1'b1;
                    end else begin
                        state_next = RUN;
                        load       = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.Flush) begin
                    state_next = IDLE;
                end else begin
                    step = 1'b1;
                    if (count == LAST) begin
                        state_next = DONE;
                        finish     = 1'b1;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count   <= '0;
            op      <= '0;
            rd      <= '0;
            operand <= '0;
            acc     <= '0;
            neg_res <= 1'b0;
            neg_a   <= 1'b0;
            result  <= '0;
            rd_out  <= '0;
        end else begin
            if (load) begin
                op      <= bus.Funct3;
                rd      <= bus.RdIn;
                operand <= bus.Funct3[2] ? b_mag : a_mag;
                acc     <= {{WIDTH{1'b0}}, (bus.Funct3[2] ? a_mag : b_mag)};
                neg_res <= a_neg_in ^ b_neg_in;
                neg_a   <= a_neg_in;
                count   <= '0;
            end else if (step) begin
                acc   <= acc_next;
                count <= finish ? '0 : count + 1'b1;
            end
            if (fast_load) begin
                result <= fast_result;
                rd_out <= bus.RdIn;
            end
            if (finish) begin
                result <= final_result;
                rd_out <= rd;
            end
        end
    end

    assign bus.Busy   = (state == RUN);
    assign bus.Done   = (state == DONE);
    assign bus.Result = result;
    assign bus.RdOut  = rd_out;
endmodule

`default_nettype wire
